// File: rtl/gpio_uart_tx.sv
// rtl/gpio_uart_tx.sv - GPIO byte capture FIFO feeding a UART 8N1 transmitter
module gpio_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    gpio_data,
  input  logic                          gpio_en,
  input  logic                          gpio_we,
  input  logic                          overflow_clr,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  state_t        state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  logic push_req;
  logic full;
  logic push;
  logic pop;
  logic baud_end;

  // Full is judged on the registered count, so a same-cycle pop never frees a slot
  always_comb begin
    push_req = gpio_we & gpio_en;
    full     = (fifo_count == FULL_COUNT);
    push     = push_req & ~full;
    baud_end = (baud_cnt == BAUD_LAST);
    pop      = (fifo_count != '0) &&
               ((state == IDLE) || ((state == STOP) && baud_end));
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= gpio_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (push_req && full) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // tx is driven from the current state, so the line trails the state by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift    <= mem[rd_ptr];
            baud_cnt <= '0;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          tx <= 1'b0;
          if (baud_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        DATA: begin
          tx <= shift[0];
          if (baud_end) begin
            baud_cnt <= '0;
            shift    <= shift >> 1;
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (baud_end) begin
            tx_done  <= 1'b1;
            baud_cnt <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
              state <= START;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_uart_tx.sv
// tb/tb_gpio_uart_tx.sv - bench for gpio_uart_tx against a frame-timeline model
module tb_gpio_uart_tx;

  localparam int C = 4;
  localparam int D = 4;
  localparam int FL = 10 * C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] gpio_data = 8'h00;
  logic       gpio_en = 1'b0;
  logic       gpio_we = 1'b0;
  logic       overflow_clr = 1'b0;
  logic       tx;
  logic       busy;
  logic       tx_done;
  logic [2:0] fifo_count;
  logic       overflow;

  gpio_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .gpio_data(gpio_data), .gpio_en(gpio_en),
    .gpio_we(gpio_we), .overflow_clr(overflow_clr), .tx(tx), .busy(busy),
    .tx_done(tx_done), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a byte queue plus a list of frames, each a (byte, line start edge) pair
  typedef struct {
    logic [7:0] b;
    int         s;
  } frame_t;

  logic [7:0] mq[$];
  frame_t     fr[$];
  int         e = 0;
  int         next_pop = 0;
  logic       m_ovf = 1'b0;

  logic [7:0] rx_q[$];
  int         start_q[$];
  int         done_fall_q[$];
  logic [9:0] smp;
  logic [9:0] last_smp;
  int         frame_pos = -1;
  int         peak = 0;

  initial begin
    logic s_we, s_en, s_clr, s_rst, ovf_set;
    logic [7:0] s_d, bb, rb;
    logic exp_tx, exp_done, exp_busy, prev_tx, prev_done, in_frame;
    int size0, j, fs;
    frame_t f;
    prev_tx = 1'b1;
    prev_done = 1'b0;
    in_frame = 1'b0;
    fs = 0;
    forever begin
      @(posedge clk);
      s_we = gpio_we; s_en = gpio_en; s_d = gpio_data; s_clr = overflow_clr; s_rst = rst_n;
      #1;
      e++;
      if (!s_rst) begin
        mq.delete();
        fr.delete();
        next_pop = 0;
        m_ovf = 1'b0;
      end else begin
        size0 = mq.size();
        if (e >= next_pop && size0 > 0) begin
          f.b = mq.pop_front();
          f.s = e + 1;
          fr.push_back(f);
          next_pop = e + FL;
        end
        ovf_set = 1'b0;
        if (s_we && s_en) begin
          if (size0 == D) ovf_set = 1'b1;
          else mq.push_back(s_d);
        end
        if (ovf_set) m_ovf = 1'b1;
        else if (s_clr) m_ovf = 1'b0;
      end
      while (fr.size() > 0 && e >= fr[0].s + FL) void'(fr.pop_front());
      exp_tx = 1'b1; exp_done = 1'b0; exp_busy = 1'b0;
      foreach (fr[i]) begin
        j = e - fr[i].s;
        bb = fr[i].b;
        if (j >= 0 && j < C) exp_tx = 1'b0;
        else if (j >= C && j < 9 * C) exp_tx = bb[(j - C) / C];
        if (j == FL - 1) exp_done = 1'b1;
        if (j >= -1 && j <= FL - 2) exp_busy = 1'b1;
      end
      check("tx", tx, exp_tx);
      check("tx_done", tx_done, exp_done);
      check("busy", busy, exp_busy);
      check("fifo_count", fifo_count, mq.size());
      check("overflow", overflow, m_ovf);

      // Independent line decoder sampling at bit centres
      if (!s_rst) begin
        in_frame = 1'b0;
        prev_tx = 1'b1;
        frame_pos = -1;
      end else begin
        if (!in_frame && prev_tx && !tx) begin
          in_frame = 1'b1;
          fs = e;
          start_q.push_back(e);
        end
        if (in_frame) begin
          j = e - fs;
          frame_pos = j;
          if (j % C == C / 2) smp[j / C] = tx;
          if (j == FL - 1) begin
            for (int k = 0; k < 8; k++) rb[k] = smp[k + 1];
            rx_q.push_back(rb);
            last_smp = smp;
            in_frame = 1'b0;
          end
        end else begin
          frame_pos = -1;
        end
        prev_tx = tx;
      end
      if (prev_done && !tx_done) done_fall_q.push_back(e);
      prev_done = tx_done;
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
  end

  task automatic wr(input logic [7:0] b);
    @(negedge clk);
    gpio_data = b;
    gpio_we = 1'b1;
    gpio_en = 1'b1;
  endtask

  task automatic stop_wr();
    @(negedge clk);
    gpio_we = 1'b0;
    gpio_en = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    for (int i = 0; i < budget && rx_q.size() < n; i++) @(negedge clk);
    check("rx_frames_within_budget", rx_q.size() >= n, 1);
  endtask

  initial begin
    int base;
    int sbase;
    int dbase;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;

    // Reset / idle
    repeat (100) @(negedge clk);
    check("idle_tx", tx, 1);
    check("idle_busy", busy, 0);
    check("idle_count", fifo_count, 0);
    check("idle_ovf", overflow, 0);

    // Single byte and latency
    base = rx_q.size(); sbase = start_q.size(); dbase = done_fall_q.size();
    wr(8'hA5);
    stop_wr();
    check("lat_edge_n", tx, 1);
    @(posedge clk); #2;
    check("lat_edge_n1", tx, 1);
    @(posedge clk); #2;
    check("lat_edge_n2", tx, 0);
    wait_rx(base + 1, 100);
    repeat (4) @(negedge clk);
    check("a5_samples", last_smp, 10'h34A);
    check("a5_byte", rx_q[base], 8'hA5);
    check("a5_done_count", done_fall_q.size() - dbase, 1);
    check("a5_done_offset", done_fall_q[dbase] - start_q[sbase], 40);
    check("a5_busy_after", busy, 0);

    // Burst
    base = rx_q.size(); sbase = start_q.size(); peak = 0;
    wr(8'h01); wr(8'h02); wr(8'h03);
    stop_wr();
    wait_rx(base + 3, 200);
    check("burst_peak", peak, 2);
    check("burst_b0", rx_q[base], 8'h01);
    check("burst_b1", rx_q[base + 1], 8'h02);
    check("burst_b2", rx_q[base + 2], 8'h03);
    check("burst_gap01", start_q[sbase + 1] - start_q[sbase], 40);
    check("burst_gap12", start_q[sbase + 2] - start_q[sbase + 1], 40);
    repeat (10) @(negedge clk);

    // Overflow
    base = rx_q.size();
    wr(8'h10);
    stop_wr();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) wr(8'h20 + 8'(i));
    stop_wr();
    check("ovf_count_sat", fifo_count, 4);
    check("ovf_flag", overflow, 1);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    check("ovf_cleared", overflow, 0);
    wait_rx(base + 5, 400);
    check("ovf_b0", rx_q[base], 8'h10);
    check("ovf_b1", rx_q[base + 1], 8'h20);
    check("ovf_b2", rx_q[base + 2], 8'h21);
    check("ovf_b3", rx_q[base + 3], 8'h22);
    check("ovf_b4", rx_q[base + 4], 8'h23);
    repeat (80) @(negedge clk);
    check("ovf_no_extra", rx_q.size(), base + 5);

    // Filtering
    base = rx_q.size();
    gpio_data = 8'hEE;
    gpio_en = 1'b1; gpio_we = 1'b0;
    repeat (10) @(negedge clk);
    gpio_en = 1'b0; gpio_we = 1'b1;
    repeat (10) @(negedge clk);
    gpio_we = 1'b0;
    repeat (50) @(negedge clk);
    check("filt_count", fifo_count, 0);
    check("filt_tx", tx, 1);
    check("filt_rx", rx_q.size(), base);

    // Mid-frame reset during data bit 3
    base = rx_q.size(); sbase = start_q.size();
    wr(8'h55); wr(8'hC3); wr(8'h3C);
    stop_wr();
    for (int i = 0; i < 100 && frame_pos != 4 * C + 1; i++) @(negedge clk);
    check("mid_reached_bit3", frame_pos, 4 * C + 1);
    check("mid_pre_tx", tx, 0);
    check("mid_pre_count", fifo_count, 2);
    #1 rst_n = 1'b0;
    #1;
    check("mid_async_tx", tx, 1);
    check("mid_async_busy", busy, 0);
    check("mid_async_count", fifo_count, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("mid_after_count", fifo_count, 0);
    check("mid_after_rx", rx_q.size(), base);
    check("mid_after_starts", start_q.size(), sbase + 1);
    check("mid_after_tx", tx, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
